// File: rtl/psram_xfer_arb_pkg.sv
// Types and constants shared by the PSRAM transfer arbiter files.
`include "psram_define.sv"

package psram_xfer_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = `PSRAM_XFER_ARB_FSM_IDLE,
        ST_ISSUE = `PSRAM_XFER_ARB_FSM_ISSUE,
        ST_WAIT  = `PSRAM_XFER_ARB_FSM_WAIT
    } arb_state_e;

    // Everything the core samples for one transfer, kept together in one hold register.
    typedef struct packed {
        logic              rdwr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } xfer_req_t;

    // Index visited at a given step of a round-robin search that starts after 'last'.
    function automatic int rr_idx(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/psram_xfer_arb_if.sv
// Requester-side and core-side signals of the PSRAM transfer arbiter.
// The arbiter uses the master modport; requesters and the core model use slave.
interface psram_xfer_arb_if #(
    parameter int NUM_REQ = 2
);
    import psram_xfer_arb_pkg::*;

    logic                           en_i;
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0]             req_rdwr_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0][MASK_W-1:0] req_wmask_i;
    logic [NUM_REQ-1:0]             rsp_valid_o;
    logic [DATA_W-1:0]              rsp_rdata_o;

    logic                           xfer_valid_o;
    logic                           xfer_rdwr_o;
    logic [ADDR_W-1:0]              bus_addr_o;
    logic [DATA_W-1:0]              bus_wr_data_o;
    logic [MASK_W-1:0]              bus_wr_mask_o;
    logic [DATA_W-1:0]              bus_rd_data_i;
    logic                           xfer_ready_i;
    logic                           xfer_done_i;

    modport master (
        input  en_i, req_valid_i, req_rdwr_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  bus_rd_data_i, xfer_ready_i, xfer_done_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output xfer_valid_o, xfer_rdwr_o, bus_addr_o, bus_wr_data_o, bus_wr_mask_o
    );

    modport slave (
        output en_i, req_valid_i, req_rdwr_i, req_addr_i, req_wdata_i, req_wmask_i,
        output bus_rd_data_i, xfer_ready_i, xfer_done_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  xfer_valid_o, xfer_rdwr_o, bus_addr_o, bus_wr_data_o, bus_wr_mask_o
    );

endinterface

// File: rtl/dffer.sv
// Register cell with synchronous active-high reset and load enable.
module dffer #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Load on enable, clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            o_q <= '0;
        else if (i_en)
            o_q <= i_d;
    end

endmodule

// File: rtl/dffr.sv
// Register cell with synchronous active-high reset.
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Load every cycle, clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            o_q <= '0;
        else
            o_q <= i_d;
    end

endmodule

// File: rtl/psram_define.sv
// Shared PSRAM defines: transfer-arbiter FSM state encodings.
`ifndef PSRAM_DEFINE_SV
`define PSRAM_DEFINE_SV

`define PSRAM_XFER_ARB_FSM_IDLE  2'd0
`define PSRAM_XFER_ARB_FSM_ISSUE 2'd1
`define PSRAM_XFER_ARB_FSM_WAIT  2'd2

`endif

// File: rtl/psram_rr_arb.sv
// Combinational grant select for the PSRAM transfer arbiter.
// Build option PSRAM_XFER_ARB_FIXED_PRIO_EN: when defined the lowest requesting
// index wins and there is no 'last' input; otherwise round-robin starting after 'last'.
module psram_rr_arb
    import psram_xfer_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
`ifndef PSRAM_XFER_ARB_FIXED_PRIO_EN
    input  logic [IDXW-1:0]    i_last,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDXW-1:0]    o_gnt_idx
);

    logic            w_found;
    logic [IDXW-1:0] w_cand;

    // First requester found in search order gets the one-hot grant and index.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
`ifdef PSRAM_XFER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDXW'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_gnt[w_cand]    = 1'b1;
                o_gnt_idx        = w_cand;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDXW'(rr_idx(int'(i_last), k, NUM_REQ));
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_gnt[w_cand]    = 1'b1;
                o_gnt_idx        = w_cand;
            end
        end
`endif
    end

endmodule

// File: rtl/psram_xfer_arb.sv
// PSRAM transfer arbiter: grants one of NUM_REQ requesters, holds its transfer
// stable on the core port until done and returns a completion pulse and read data.
// Build option PSRAM_XFER_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for enable, core idle and a pending request; grants on entry condition
// ISSUE | xfer_valid_o high until the core drops xfer_ready_i
// WAIT  | transfer in flight, waiting for xfer_done_i
module psram_xfer_arb
    import psram_xfer_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    psram_xfer_arb_if.master bus
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_owner;
    logic               r_xfer_valid;
    xfer_req_t          r_hold;
    logic [DATA_W-1:0]  r_rdata;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDXW-1:0]    w_gnt_idx;
    logic               w_grant;
    logic               w_done;
    xfer_req_t          w_req_sel;
    logic [NUM_REQ-1:0] w_rsp_valid_d;

`ifndef PSRAM_XFER_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]    r_last;
`endif

    psram_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_arb (
`ifndef PSRAM_XFER_ARB_FIXED_PRIO_EN
        .i_last    (r_last),
`endif
        .i_req     (bus.req_valid_i),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // rst_i gating keeps req_ready_o low during a reset cycle even if the FSM sits in IDLE.
    assign w_grant = (r_state == ST_IDLE) && !rst_i && bus.en_i &&
                     bus.xfer_ready_i && (|bus.req_valid_i);
    assign w_done  = (r_state == ST_WAIT) && bus.xfer_done_i;

    assign w_req_sel = {bus.req_rdwr_i[w_gnt_idx], bus.req_addr_i[w_gnt_idx],
                        bus.req_wdata_i[w_gnt_idx], bus.req_wmask_i[w_gnt_idx]};

    assign w_rsp_valid_d = w_done ? r_owner : '0;

    // Transfer fields change only on a grant so the core sees them stable until done.
    dffer #(.WIDTH($bits(xfer_req_t))) u_hold (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_en  (w_grant),
        .i_d   (w_req_sel),
        .o_q   (r_hold)
    );

    dffer #(.WIDTH(DATA_W)) u_rdata (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_en  (w_done && r_hold.rdwr),
        .i_d   (bus.bus_rd_data_i),
        .o_q   (r_rdata)
    );

    dffr #(.WIDTH(NUM_REQ)) u_rsp_valid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_d   (w_rsp_valid_d),
        .o_q   (r_rsp_valid)
    );

    // Transfer sequencing; xfer_valid_o is cleared on leaving ISSUE so the core never
    // sees it again after recovering to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_xfer_valid <= 1'b0;
`ifndef PSRAM_XFER_ARB_FIXED_PRIO_EN
            r_last       <= IDXW'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_gnt;
                        r_xfer_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
`ifndef PSRAM_XFER_ARB_FIXED_PRIO_EN
                        r_last       <= w_gnt_idx;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (!bus.xfer_ready_i) begin
                        r_xfer_valid <= 1'b0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.xfer_done_i)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_xfer_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = w_grant ? w_gnt : '0;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rdata;
    assign bus.xfer_valid_o  = r_xfer_valid;
    assign bus.xfer_rdwr_o   = r_hold.rdwr;
    assign bus.bus_addr_o    = r_hold.addr;
    assign bus.bus_wr_data_o = r_hold.wdata;
    assign bus.bus_wr_mask_o = r_hold.wmask;

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Directed testbench for psram_xfer_arb with a small PSRAM core model.
module tb_psram_xfer_arb;

    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    psram_xfer_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    psram_xfer_arb #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // core model state
    int          core_lat  = 2;
    int          core_hold = 0;
    int          core_wait = 0;
    int          core_cnt  = 0;
    bit          core_busy = 1'b0;
    int          core_xfers = 0;
    int          stable_err = 0;
    logic [63:0] core_rdata_val = 64'h0;
    logic [31:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wmask;
    logic        cap_rdwr;

    // monitors
    int vcount = 0;
    int rsp_pulses = 0;
    int glog[$];

    // Core model: acts on the falling edge, leaves idle after core_hold cycles of
    // xfer_valid_o, stays busy core_lat cycles, then pulses done and returns to idle.
    always @(negedge clk) begin
        bus.xfer_done_i = 1'b0;
        if (rst) begin
            core_busy         = 1'b0;
            core_wait         = 0;
            bus.xfer_ready_i  = 1'b1;
            bus.bus_rd_data_i = 64'h0;
        end else if (!core_busy) begin
            if (bus.xfer_valid_o) begin
                if (core_wait < core_hold) begin
                    core_wait++;
                end else begin
                    core_wait        = 0;
                    core_busy        = 1'b1;
                    bus.xfer_ready_i = 1'b0;
                    core_cnt         = core_lat;
                    core_xfers++;
                    cap_addr  = bus.bus_addr_o;
                    cap_wdata = bus.bus_wr_data_o;
                    cap_wmask = bus.bus_wr_mask_o;
                    cap_rdwr  = bus.xfer_rdwr_o;
                end
            end
        end else begin
            if (bus.bus_addr_o !== cap_addr || bus.bus_wr_data_o !== cap_wdata ||
                bus.bus_wr_mask_o !== cap_wmask || bus.xfer_rdwr_o !== cap_rdwr)
                stable_err++;
            if (core_cnt > 0) begin
                core_cnt--;
            end else begin
                bus.xfer_done_i   = 1'b1;
                bus.bus_rd_data_i = core_rdata_val;
                core_busy         = 1'b0;
                bus.xfer_ready_i  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.xfer_valid_o) vcount++;
        if (|bus.rsp_valid_o) rsp_pulses++;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready_o[i]) glog.push_back(i);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge (+1) where the core raises xfer_done_i.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (bus.xfer_done_i) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
    endtask

    logic [63:0] exp_rdata;
    int rem0, rem1, gsz, vbase, xbase, rbase, sbase;
    int exp_order[8];

    initial begin
        rst = 1'b1;
        bus.en_i        = 1'b0;
        bus.req_valid_i = '0;
        bus.req_rdwr_i  = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_wmask_i = '0;
        repeat (3) tick();

        // ---- reset state
        chk("rst_req_ready",  128'(bus.req_ready_o),   128'(2'b00));
        chk("rst_rsp_valid",  128'(bus.rsp_valid_o),   128'(2'b00));
        chk("rst_xfer_valid", 128'(bus.xfer_valid_o),  128'(1'b0));
        chk("rst_xfer_rdwr",  128'(bus.xfer_rdwr_o),   128'(1'b0));
        chk("rst_bus_addr",   128'(bus.bus_addr_o),    128'(32'h0));
        chk("rst_bus_wdata",  128'(bus.bus_wr_data_o), 128'(64'h0));
        chk("rst_bus_wmask",  128'(bus.bus_wr_mask_o), 128'(8'h0));
        chk("rst_rsp_rdata",  128'(bus.rsp_rdata_o),   128'(64'h0));
        rst = 1'b0;
        tick();

        // ---- single read from req0
        core_rdata_val = 64'h1122_3344_5566_7788;
        bus.en_i = 1'b1;
        bus.req_rdwr_i[0] = 1'b1;
        bus.req_addr_i[0] = 32'h0000_0100;
        bus.req_valid_i   = 2'b01;
        #1;
        chk("t1_ready_c0",   128'(bus.req_ready_o),  128'(2'b01));
        chk("t1_xvalid_c0",  128'(bus.xfer_valid_o), 128'(1'b0));
        tick();
        bus.req_valid_i = 2'b00;
        chk("t1_xvalid_c1",  128'(bus.xfer_valid_o), 128'(1'b1));
        chk("t1_ready_c1",   128'(bus.req_ready_o),  128'(2'b00));
        chk("t1_addr",       128'(bus.bus_addr_o),   128'(32'h0000_0100));
        chk("t1_rdwr",       128'(bus.xfer_rdwr_o),  128'(1'b1));
        tick();
        chk("t1_xvalid_c2",  128'(bus.xfer_valid_o), 128'(1'b0));
        wait_done("t1");
        chk("t1_rsp_pre",    128'(bus.rsp_valid_o),  128'(2'b00));
        tick();
        chk("t1_rsp",        128'(bus.rsp_valid_o),  128'(2'b01));
        chk("t1_rdata",      128'(bus.rsp_rdata_o),  128'(64'h1122_3344_5566_7788));
        tick();
        chk("t1_rsp_pulse",  128'(bus.rsp_valid_o),  128'(2'b00));

        // ---- back-to-back from both requesters, fresh arbitration pointer
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        core_rdata_val = 64'hCAFE_F00D_0123_4567;
        exp_rdata = 64'hCAFE_F00D_0123_4567;
`ifdef PSRAM_XFER_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        glog.delete();
        gsz  = 0;
        rem0 = 4;
        rem1 = 4;
        bus.req_rdwr_i  = 2'b11;
        bus.req_addr_i[0] = 32'h0000_1000;
        bus.req_addr_i[1] = 32'h0000_1100;
        bus.req_valid_i = 2'b11;
        for (int c = 0; c < 400 && (rem0 > 0 || rem1 > 0); c++) begin
            tick();
            if (glog.size() > gsz) begin
                gsz = glog.size();
                if (glog[gsz-1] == 0) begin
                    rem0--;
                    if (rem0 == 0) bus.req_valid_i[0] = 1'b0;
                end else begin
                    rem1--;
                    if (rem1 == 0) bus.req_valid_i[1] = 1'b0;
                end
            end
        end
        wait_done("t2");
        tick();
        tick();
        chk("t2_grant_count", 128'(glog.size()), 128'(8));
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_grant_%0d", i), 128'(glog[i]), 128'(exp_order[i]));
        chk("t2_rdata", 128'(bus.rsp_rdata_o), 128'(exp_rdata));

        // ---- write from req1 while req0 and req1 inputs move during the transfer
        sbase = stable_err;
        bus.req_rdwr_i[1]  = 1'b0;
        bus.req_addr_i[1]  = 32'h0000_2000;
        bus.req_wdata_i[1] = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.req_wmask_i[1] = 8'h0F;
        bus.req_valid_i    = 2'b10;
        #1;
        chk("t3_ready", 128'(bus.req_ready_o), 128'(2'b10));
        tick();
        bus.req_valid_i    = 2'b00;
        bus.req_addr_i[0]  = 32'h0000_DEAD;
        bus.req_wdata_i[0] = 64'h1234_5678_9ABC_DEF0;
        bus.req_wmask_i[0] = 8'hF0;
        bus.req_rdwr_i[0]  = 1'b1;
        bus.req_addr_i[1]  = 32'h0000_BEEF;
        bus.req_wdata_i[1] = 64'h0;
        chk("t3_addr",  128'(bus.bus_addr_o),    128'(32'h0000_2000));
        chk("t3_wdata", 128'(bus.bus_wr_data_o), 128'(64'hA5A5_A5A5_A5A5_A5A5));
        chk("t3_wmask", 128'(bus.bus_wr_mask_o), 128'(8'h0F));
        chk("t3_rdwr",  128'(bus.xfer_rdwr_o),   128'(1'b0));
        tick();
        bus.req_addr_i[0] = 32'h0000_5555;
        tick();
        chk("t3_addr_mid", 128'(bus.bus_addr_o), 128'(32'h0000_2000));
        wait_done("t3");
        chk("t3_addr_done", 128'(bus.bus_addr_o), 128'(32'h0000_2000));
        tick();
        chk("t3_rsp",    128'(bus.rsp_valid_o), 128'(2'b10));
        chk("t3_rdata",  128'(bus.rsp_rdata_o), 128'(exp_rdata));
        chk("t3_stable", 128'(stable_err - sbase), 128'(0));
        tick();

        // ---- grant enable low blocks new grants
        bus.en_i = 1'b0;
        bus.req_rdwr_i[0] = 1'b0;
        bus.req_addr_i[0] = 32'h0000_0300;
        bus.req_valid_i   = 2'b01;
        tick();
        chk("t4_blocked_a", 128'(bus.req_ready_o),  128'(2'b00));
        tick();
        tick();
        chk("t4_blocked_b", 128'(bus.req_ready_o),  128'(2'b00));
        chk("t4_no_xvalid", 128'(bus.xfer_valid_o), 128'(1'b0));
        bus.en_i = 1'b1;
        #1;
        chk("t4_ready", 128'(bus.req_ready_o), 128'(2'b01));
        tick();
        bus.req_valid_i = 2'b00;
        chk("t4_xvalid", 128'(bus.xfer_valid_o), 128'(1'b1));
        chk("t4_addr",   128'(bus.bus_addr_o),   128'(32'h0000_0300));
        wait_done("t4");
        tick();
        chk("t4_rsp",   128'(bus.rsp_valid_o), 128'(2'b01));
        chk("t4_rdata", 128'(bus.rsp_rdata_o), 128'(exp_rdata));
        tick();

        // ---- core stays idle 3 extra cycles after xfer_valid_o
        core_hold = 3;
        core_rdata_val = 64'h0BAD_BEEF_0000_0042;
        vbase = vcount;
        xbase = core_xfers;
        bus.req_rdwr_i[0] = 1'b1;
        bus.req_addr_i[0] = 32'h0000_0400;
        bus.req_valid_i   = 2'b01;
        tick();
        bus.req_valid_i = 2'b00;
        wait_done("t5");
        tick();
        chk("t5_rsp",   128'(bus.rsp_valid_o), 128'(2'b01));
        chk("t5_rdata", 128'(bus.rsp_rdata_o), 128'(64'h0BAD_BEEF_0000_0042));
        repeat (5) tick();
        chk("t5_valid_cycles", 128'(vcount - vbase),     128'(4));
        chk("t5_core_xfers",   128'(core_xfers - xbase), 128'(1));
        core_hold = 0;

        // ---- reset while waiting on the core
        core_lat = 5;
        bus.req_rdwr_i[0] = 1'b1;
        bus.req_addr_i[0] = 32'h0000_0500;
        bus.req_valid_i   = 2'b01;
        tick();
        bus.req_valid_i = 2'b00;
        tick();
        chk("t6_in_wait_xvalid", 128'(bus.xfer_valid_o), 128'(1'b0));
        chk("t6_in_wait_addr",   128'(bus.bus_addr_o),   128'(32'h0000_0500));
        rst = 1'b1;
        rbase = rsp_pulses;
        bus.req_valid_i = 2'b01;
        tick();
        chk("t6_rst_req_ready", 128'(bus.req_ready_o),   128'(2'b00));
        chk("t6_rst_rsp",       128'(bus.rsp_valid_o),   128'(2'b00));
        chk("t6_rst_xvalid",    128'(bus.xfer_valid_o),  128'(1'b0));
        chk("t6_rst_addr",      128'(bus.bus_addr_o),    128'(32'h0));
        chk("t6_rst_rdwr",      128'(bus.xfer_rdwr_o),   128'(1'b0));
        chk("t6_rst_rdata",     128'(bus.rsp_rdata_o),   128'(64'h0));
        rst = 1'b0;
        bus.req_valid_i = 2'b00;
        repeat (10) tick();
        chk("t6_no_rsp", 128'(rsp_pulses - rbase), 128'(0));
        core_lat = 2;
        bus.req_rdwr_i[1]  = 1'b0;
        bus.req_addr_i[1]  = 32'h0000_0600;
        bus.req_wdata_i[1] = 64'h5A5A_5A5A_5A5A_5A5A;
        bus.req_wmask_i[1] = 8'hFF;
        bus.req_valid_i    = 2'b10;
        #1;
        chk("t6_after_ready", 128'(bus.req_ready_o), 128'(2'b10));
        tick();
        bus.req_valid_i = 2'b00;
        chk("t6_after_wdata", 128'(bus.bus_wr_data_o), 128'(64'h5A5A_5A5A_5A5A_5A5A));
        wait_done("t6");
        tick();
        chk("t6_after_rsp", 128'(bus.rsp_valid_o), 128'(2'b10));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_xfer_arb.md
# psram_xfer_arb

Multi-requester transfer arbiter sitting between N bus-side masters and the PSRAM core's single transfer port. Picks one pending request (round-robin by default), holds its address/data/mask stable on the core inputs for the whole transfer, handshakes with the core's valid/ready/done protocol and returns read data plus a one-cycle completion pulse to the owning requester. The core serves one transfer at a time; this block is the only driver of its `xfer_*`/`bus_*` inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `clk_i` in 1: clock, same domain as the core.
- `rst_i` in 1: reset, synchronous, active-high; shared with the core's reset source.
- `en_i` in 1: grant enable; low blocks new grants, in-flight transfer completes.
- `req_valid_i` in NUM_REQ: per-requester request pending; held until accepted.
- `req_ready_o` out NUM_REQ: one-hot, one-cycle accept pulse.
- `req_rdwr_i` in NUM_REQ: 1 = read, 0 = write.
- `req_addr_i` in NUM_REQ×32: byte address.
- `req_wdata_i` in NUM_REQ×64: write data.
- `req_wmask_i` in NUM_REQ×8: write byte mask.
- `rsp_valid_o` out NUM_REQ: one-hot, one-cycle completion pulse (reads and writes).
- `rsp_rdata_o` out 64: read data, shared, valid with `rsp_valid_o`.
- `xfer_valid_o` out 1: to core.
- `xfer_rdwr_o` out 1: to core.
- `bus_addr_o` out 32: to core.
- `bus_wr_data_o` out 64: to core.
- `bus_wr_mask_o` out 8: to core.
- `bus_rd_data_i` in 64: from core.
- `xfer_ready_i` in 1: core idle (level).
- `xfer_done_i` in 1: core completion (one-cycle pulse).

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if `en_i && xfer_ready_i && |req_valid_i`, pick winner `g`, latch its rdwr/addr/wdata/wmask into hold registers, record owner `g`, pulse `req_ready_o[g]`, go ISSUE. Otherwise stay.
- ISSUE: `xfer_valid_o`=1. When `xfer_ready_i`=0 (core has left idle), drop `xfer_valid_o` and go WAIT. `xfer_valid_o` must never be high while in WAIT, so the core does not re-trigger after recovery.
- WAIT: on `xfer_done_i`, if the transfer was a read, load `bus_rd_data_i` into the `rsp_rdata_o` register. Pulse `rsp_valid_o[owner]` next cycle. Go IDLE.
- `bus_addr_o`, `bus_wr_data_o`, `bus_wr_mask_o` and `xfer_rdwr_o` come straight from the hold registers. They change only on an IDLE grant and stay stable from ISSUE through done, because the core samples them throughout the transfer.
- Round-robin: pointer `last` = last granted index. Search starts at `last+1` mod NUM_REQ and wraps. `last` updates only on a grant.
- A `xfer_done_i` seen outside WAIT is ignored.
- Requests whose `req_valid_i` drops before acceptance are simply not granted. No error is raised.

## Timing
- Reset values:
  - `req_ready_o`, `rsp_valid_o`, `xfer_valid_o`, `xfer_rdwr_o`: 0.
  - `bus_addr_o`, `bus_wr_data_o`, `bus_wr_mask_o`, `rsp_rdata_o`: 0.
  - FSM: IDLE. `last`: NUM_REQ-1, so requester 0 wins first.
- Cycle sequence from grant:
  - Cycle 0: grant in IDLE, `req_ready_o` pulse.
  - Cycle 1: `xfer_valid_o` high.
  - `xfer_valid_o` falls the cycle after `xfer_ready_i` is first seen low.
- `rsp_valid_o` is asserted exactly 1 cycle after `xfer_done_i`.
- The next grant is possible in the same cycle `rsp_valid_o` is high, since the FSM is already back in IDLE.
- Reset mid-transfer: FSM returns to IDLE and all outputs return to reset values. No response is issued for the aborted request.

## Configuration
- `PSRAM_XFER_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last` pointer is not implemented.
  - Undefined (default): round-robin as above.

## Structure
- FSM state encodings go in `psram_define.sv` as `` `PSRAM_XFER_ARB_FSM_IDLE/ISSUE/WAIT ``, alongside the existing PSRAM defines.
- Sub-module `psram_rr_arb` (combinational grant select: `req`, `last` → one-hot `gnt` + index). It contains the `PSRAM_XFER_ARB_FIXED_PRIO_EN` switch.
- Hold/response registers use the existing `dffer`/`dffr` cells.

## Test plan
- Single read, req0 addr 0x0000_0100: core model returns 0x1122_3344_5566_7788 → `req_ready_o`=01 at cycle 0, `xfer_valid_o` at cycle 1, `rsp_valid_o[0]` with that data 1 cycle after done.
- req0 and req1 valid together, 4 back-to-back transfers each → grant order 0,1,0,1,…. Under `PSRAM_XFER_ARB_FIXED_PRIO_EN`: 0,0,0,0, then 1.
- Write from req1 (data 0xA5…A5, mask 0x0F) while req0 changes its inputs mid-transfer → `bus_*` stay at req1's values from grant until done; `rsp_rdata_o` is unchanged.
- `en_i`=0 with requests pending → no `req_ready_o`. `en_i` rises → grant next cycle.
- Core holds `xfer_ready_i` high for 3 cycles after `xfer_valid_o` → `xfer_valid_o` stays high for those cycles, then exactly one core transfer occurs.
- `rst_i` asserted in WAIT → all outputs 0 next cycle and no `rsp_valid_o`. A later request is granted normally.
